// File: rtl/address_generator_tiled.sv
// Tiled systolic-array operand address generator: one skewed address lane per
// array row, with start/busy/done handshake, stall, and row-count clamping.
module address_generator_tiled #(
  parameter int ADDR_WIDTH        = 16,
  parameter int ARRAY_N           = 8,
  parameter int LEN_WIDTH         = 8,
  parameter int CONCAT_ADDR_WIDTH = ADDR_WIDTH * ARRAY_N
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stall,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [$clog2(ARRAY_N):0]     num_rows,
  input  logic [LEN_WIDTH-1:0]         k_len,
  input  logic [ADDR_WIDTH-1:0]        row_stride,
  input  logic                         mode,
  output logic [CONCAT_ADDR_WIDTH-1:0] address,
  output logic [ARRAY_N-1:0]           enable,
  output logic                         busy,
  output logic                         done
);

  localparam int NRW = $clog2(ARRAY_N) + 1;
  // Step counter must hold k_len + ARRAY_N - 1 without overflow.
  localparam int TW  = ((LEN_WIDTH > NRW) ? LEN_WIDTH : NRW) + 1;
  localparam logic [NRW-1:0] ROWS_MAX = NRW'(ARRAY_N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic [TW-1:0]           r_t;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [ADDR_WIDTH-1:0]   r_stride;
  logic [NRW-1:0]          r_rows;
  logic [LEN_WIDTH-1:0]    r_klen;
  logic                    r_mode;

  logic                    w_launch;
  logic [NRW-1:0]          w_rows_clamped;
  logic [ADDR_WIDTH-1:0]   w_cfg_base;
  logic [ADDR_WIDTH-1:0]   w_cfg_stride;
  logic [NRW-1:0]          w_cfg_rows;
  logic [LEN_WIDTH-1:0]    w_cfg_klen;
  logic                    w_cfg_mode;
  logic [TW-1:0]           w_total;
  logic [TW-1:0]           w_k;
  logic [ADDR_WIDTH-1:0]   w_ofs;
  logic [CONCAT_ADDR_WIDTH-1:0] w_lane_addr;
  logic [ARRAY_N-1:0]      w_lane_en;

  assign w_launch       = (r_state == S_IDLE) && start;
  assign w_rows_clamped = (num_rows > ROWS_MAX) ? ROWS_MAX : num_rows;

  // Step 0 is issued on the start edge itself, so it must see the live inputs.
  assign w_cfg_base   = (r_state == S_IDLE) ? base_addr      : r_base;
  assign w_cfg_stride = (r_state == S_IDLE) ? row_stride     : r_stride;
  assign w_cfg_rows   = (r_state == S_IDLE) ? w_rows_clamped : r_rows;
  assign w_cfg_klen   = (r_state == S_IDLE) ? k_len          : r_klen;
  assign w_cfg_mode   = (r_state == S_IDLE) ? mode           : r_mode;

  // An empty tile still spends exactly one step in RUN.
  assign w_total = ((r_rows == '0) || (r_klen == '0)) ? TW'(1)
                 : TW'(r_klen) + TW'(r_rows) - TW'(1);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_lane_addr = '0;
    w_lane_en   = '0;
    w_k         = '0;
    w_ofs       = '0;
    for (int r = 0; r < ARRAY_N; r++) begin
      w_k = r_t - TW'(r);
      if ((TW'(r) < TW'(w_cfg_rows)) && (r_t >= TW'(r)) && (w_k < TW'(w_cfg_klen))) begin
        w_lane_en[r] = 1'b1;
        w_ofs = w_cfg_mode ? (ADDR_WIDTH'(w_k) * w_cfg_stride + ADDR_WIDTH'(r))
                           : (ADDR_WIDTH'(r) * w_cfg_stride + ADDR_WIDTH'(w_k));
        w_lane_addr[r*ADDR_WIDTH +: ADDR_WIDTH] = w_cfg_base + w_ofs;
      end
    end
  end

  // NOTE: configuration is pure datapath, only read after a launch has written it, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_launch) begin
      r_base   <= base_addr;
      r_stride <= row_stride;
      r_rows   <= w_rows_clamped;
      r_klen   <= k_len;
      r_mode   <= mode;
    end
  end

  // r_t is the next step to issue; it is 0 whenever the block is idle.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      address <= '0;
      enable  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_state <= S_RUN;
            r_t     <= r_t + TW'(1);
            address <= w_lane_addr;
            enable  <= w_lane_en;
            busy    <= 1'b1;
          end
        end
        S_RUN: begin
          if (stall) begin
            enable <= '0;
          end else if (r_t >= w_total) begin
            r_state <= S_DONE;
            address <= '0;
            enable  <= '0;
            done    <= 1'b1;
          end else begin
            r_t     <= r_t + TW'(1);
            address <= w_lane_addr;
            enable  <= w_lane_en;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_t     <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_t     <= '0;
          address <= '0;
          enable  <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_address_generator_tiled.sv
// Self-checking bench for address_generator_tiled: directed test-plan tiles plus
// randomized tiles compared cycle by cycle against a behavioural model.
module tb_address_generator_tiled;

  localparam int AW  = 16;
  localparam int N   = 8;
  localparam int LW  = 8;
  localparam int CW  = AW * N;
  localparam int NRW = $clog2(N) + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           stall;
  logic [AW-1:0]  base_addr;
  logic [NRW-1:0] num_rows;
  logic [LW-1:0]  k_len;
  logic [AW-1:0]  row_stride;
  logic           mode;
  logic [CW-1:0]  address;
  logic [N-1:0]   enable;
  logic           busy;
  logic           done;

  address_generator_tiled #(
    .ADDR_WIDTH(AW),
    .ARRAY_N(N),
    .LEN_WIDTH(LW),
    .CONCAT_ADDR_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stall(stall),
    .base_addr(base_addr),
    .num_rows(num_rows),
    .k_len(k_len),
    .row_stride(row_stride),
    .mode(mode),
    .address(address),
    .enable(enable),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected outputs for the current cycle.
  int           exp_lane [N];
  logic [N-1:0] exp_en;
  logic         exp_busy;
  logic         exp_done;

  // Lane addresses straight from the addressing rules, in plain integer arithmetic.
  function automatic void model_step(input int t, input int base, input int rows,
                                     input int klen, input int stride, input int md);
    exp_en = '0;
    for (int r = 0; r < N; r++) begin
      int k;
      k = t - r;
      if (r < rows && k >= 0 && k < klen) begin
        exp_en[r]   = 1'b1;
        exp_lane[r] = md ? ((base + k * stride + r) % 65536) : ((base + r * stride + k) % 65536);
      end else begin
        exp_lane[r] = 0;
      end
    end
  endfunction

  function automatic logic [CW-1:0] exp_bus();
    logic [CW-1:0] b;
    b = '0;
    for (int r = 0; r < N; r++) b[r*AW +: AW] = exp_lane[r][AW-1:0];
    return b;
  endfunction

  task automatic check_outputs(input string name);
    check({name, ":addr"}, address, exp_bus());
    check({name, ":en"},   CW'(enable), CW'(exp_en));
    check({name, ":busy"}, CW'(busy), CW'(exp_busy));
    check({name, ":done"}, CW'(done), CW'(exp_done));
  endtask

  // Launch one tile and follow it until the idle cycle after done (or a reset).
  task automatic run_tile(input string name, input int base, input int rows, input int klen,
                          input int stride, input int md, input logic [63:0] stall_mask,
                          input int stall_pct, input int extra_start_cyc, input int reset_cyc);
    int  r_eff;
    int  t_total;
    int  nxt;
    int  c;
    bit  in_run;
    bit  in_done;
    r_eff   = (rows > N) ? N : rows;
    t_total = (r_eff == 0 || klen == 0) ? 1 : klen + r_eff - 1;

    base_addr  = AW'(base);
    num_rows   = NRW'(rows);
    k_len      = LW'(klen);
    row_stride = AW'(stride);
    mode       = md[0];
    start      = 1'b1;
    stall      = 1'($urandom_range(1));
    @(posedge clk);
    #1;
    model_step(0, base, r_eff, klen, stride, md);
    exp_busy = 1'b1;
    exp_done = 1'b0;
    nxt      = 1;
    in_run   = 1'b1;
    in_done  = 1'b0;

    // Configuration changes after the start edge must be ignored.
    base_addr  = AW'($urandom);
    num_rows   = NRW'($urandom);
    k_len      = LW'($urandom);
    row_stride = AW'($urandom);
    mode       = 1'($urandom);

    for (c = 1; c < 1000; c++) begin
      check_outputs($sformatf("%s@%0d", name, c));
      if (!in_run && !in_done) break;
      stall = stall_mask[c[5:0]] && (c < 64);
      if (stall_pct > 0 && $urandom_range(99) < stall_pct) stall = 1'b1;
      start = (c == extra_start_cyc);
      reset = (c == reset_cyc);
      @(posedge clk);
      #1;
      if (c == reset_cyc) begin
        for (int r = 0; r < N; r++) exp_lane[r] = 0;
        exp_en   = '0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        in_run   = 1'b0;
        in_done  = 1'b0;
      end else if (in_done) begin
        exp_busy = 1'b0;
        exp_done = 1'b0;
        in_done  = 1'b0;
      end else if (stall) begin
        exp_en = '0;
      end else if (nxt == t_total) begin
        for (int r = 0; r < N; r++) exp_lane[r] = 0;
        exp_en   = '0;
        exp_done = 1'b1;
        in_run   = 1'b0;
        in_done  = 1'b1;
      end else begin
        model_step(nxt, base, r_eff, klen, stride, md);
        nxt++;
      end
    end
    start = 1'b0;
    reset = 1'b0;
    stall = 1'b0;
    check({name, ":finished"}, CW'({in_run, in_done}), '0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    stall      = 1'b0;
    base_addr  = '0;
    num_rows   = '0;
    k_len      = '0;
    row_stride = '0;
    mode       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int r = 0; r < N; r++) exp_lane[r] = 0;
    exp_en   = '0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    check_outputs("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_tile("rowmaj",  'h0100, 8,  4, 'h10, 0, 64'h0, 0, -1, -1);
    run_tile("colmaj",  0,      4,  2, 8,    1, 64'h0, 0, -1, -1);
    run_tile("wrap",    'hFFFE, 1,  4, 1,    0, 64'h0, 0, -1, -1);
    run_tile("clamp12", 'h0100, 12, 4, 'h10, 0, 64'h0, 0, -1, -1);
    run_tile("rows0",   'h0100, 0,  4, 'h10, 0, 64'h0, 0, -1, -1);
    run_tile("klen0",   'h0100, 5,  0, 'h10, 1, 64'h0, 0, -1, -1);
    run_tile("stall",   'h0100, 8,  4, 'h10, 0, 64'h18, 0, -1, -1);
    run_tile("start2",  'h0100, 8,  4, 'h10, 0, 64'h0, 0, 5, -1);
    run_tile("reset",   'h0100, 8,  4, 'h10, 0, 64'h0, 0, -1, 6);
    // After an abandoned tile, no done may appear while idle.
    repeat (3) begin
      @(posedge clk);
      #1;
      check("post_reset:done", CW'(done), '0);
      check("post_reset:busy", CW'(busy), '0);
    end
    run_tile("fresh",   'h0100, 8,  4, 'h10, 0, 64'h0, 0, -1, -1);
    run_tile("longk",   'h1234, 8, 255, 'h0101, 1, 64'h0, 10, -1, -1);

    for (int i = 0; i < 40; i++) begin
      run_tile($sformatf("rnd%0d", i), int'($urandom_range(65535)), int'($urandom_range(15)),
               int'($urandom_range(24)), int'($urandom_range(65535)), int'($urandom_range(1)),
               64'h0, (i % 2 == 0) ? 0 : 30, int'($urandom_range(1, 12)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/address_generator_tiled.md
# address_generator_tiled

Parametrised successor to the systolic-array operand address generator. On a start pulse it emits one skewed address stream per array row, with a configurable vector length, row stride and row-major/column-major mode, so an ARRAY_N-row systolic array can be fed from its local operand buffers. The block adds a start/busy/done handshake and a stall input, and it clamps and wraps inputs. It sits between the tile controller and the per-row operand BRAM read ports.

## Interface
- ADDR_WIDTH, 16: width of each per-row address lane.
- ARRAY_N, 8: number of array rows, which is also the number of lanes.
- LEN_WIDTH, 8: width of the vector-length field.
- CONCAT_ADDR_WIDTH, ADDR_WIDTH*ARRAY_N: width of the concatenated address bus.

Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- stall  in  1  freezes progress while high.
- base_addr  in  ADDR_WIDTH  tile base address; latched at start.
- num_rows  in  $clog2(ARRAY_N)+1  active rows; latched at start.
- k_len  in  LEN_WIDTH  addresses per row; latched at start.
- row_stride  in  ADDR_WIDTH  stride; latched at start.
- mode  in  1  0 = row-major, 1 = column-major; latched at start.
- address  out  CONCAT_ADDR_WIDTH  lane r occupies bits [r*ADDR_WIDTH +: ADDR_WIDTH].
- enable  out  ARRAY_N  bit r = lane r address valid this cycle.
- busy  out  1  high while a tile is in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- States are IDLE, RUN and DONE.
  - IDLE to RUN on the edge sampling start=1. All configuration is latched on that edge and t is cleared to 0.
  - RUN to DONE on the edge after the last step, t = T-1.
  - DONE to IDLE unconditionally after one cycle.
- Effective rows R = min(num_rows, ARRAY_N). Total steps T = k_len + R - 1.
- If R=0 or k_len=0, RUN lasts one cycle with no enables, then DONE follows.
- At step t, lane r is active when r < R, t >= r, and k = t - r < k_len.
- Lane address by mode:
  - mode 0: base_addr + r*row_stride + k.
  - mode 1: base_addr + k*row_stride + r.
  - All arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
- Inactive lanes drive address 0 and enable 0.
- stall=1 in RUN:
  - t holds, and enable is forced to all-zero.
  - address lanes hold their previous values.
  - When stall drops, the same step t is issued. Steps are neither skipped nor repeated.
- stall is ignored in IDLE and DONE.
- start in RUN or DONE is ignored; there is no queuing.
- Configuration inputs may change freely after the start edge without effect.
- reset in any state:
  - next state IDLE, t=0.
  - address=0, enable=0, busy=0, done=0.
  - Any tile in flight is abandoned and no done is produced.

## Timing
- All outputs are registered.
- Reset values: address=0, enable=0, busy=0, done=0, state IDLE.
- Latency: lane 0's first address and enable[0] are valid in the cycle immediately after the start edge.
- Step t appears in the (t+1)-th unstalled RUN cycle after start.
- busy is high from the cycle after the start edge through the DONE cycle inclusive.
- done is high for exactly one cycle, the cycle after the last enable cycle. enable is 0 during done.
- Unstalled tile: start to done takes T+1 cycles. Each stall cycle adds exactly one cycle.
- Back-to-back operation: start may be asserted during the DONE cycle's following IDLE cycle. The minimum start-to-start spacing is T+3 cycles.

## Test plan
- Row-major skew, with ARRAY_N=8, base=0x0100, num_rows=8, k_len=4, stride=0x10, mode=0:
  - cycle 1: lane0=0x0100, enable=0x01.
  - cycle 2: lane0=0x0101, lane1=0x0110, enable=0x03.
  - cycle 11: lane7=0x0173, enable=0x80.
  - cycle 12: done=1, enable=0.
- Column-major, with base=0, stride=8, num_rows=4, k_len=2, mode=1:
  - cycle 1: lane0=0, enable=0x01.
  - cycle 2: lane0=8, lane1=1, enable=0x03.
  - cycle 5: lane3=11, enable=0x08.
  - cycle 6: done.
- Wrap and clamp:
  - base=0xFFFE, stride=1, num_rows=1, k_len=4, mode=0: lane0 sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
  - num_rows=12 behaves identically to num_rows=8.
  - num_rows=0: done at cycle 2, enable never set.
- Stall, using the first scenario:
  - stall high during cycles 4–5 forces enable=0 and holds the address.
  - cycle 6 repeats the cycle-4 step pattern (lane0=0x0103, enable=0x0F).
  - done moves to cycle 14.
- Handshake: a second start at cycle 5 of a running tile is ignored, and busy is unaffected.
- Reset: reset asserted at cycle 6 of a running tile gives all outputs 0 and busy=0 the next cycle, with no done pulse. A fresh start then runs normally.
